// File: rtl/fwd_pkg.sv
// Shared types for the operand-forwarding / hazard controller: stage tags,
// operand-mux select encoding and the producer-match helper.
package fwd_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              is_load;
    } stage_tag_t;

    typedef enum logic [1:0] {
        SEL_IDEX = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_WB   = 2'b10,
        SEL_LOAD = 2'b11
    } fwd_sel_e;

    // x0 is hard-wired zero, so a producer targeting it never forwards.
    function automatic logic tag_hit(stage_tag_t t, logic [REG_AW-1:0] src, logic use_src);
        return t.valid && t.wen && (t.rd != '0) && (t.rd == src) && use_src;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// Combinational forwarding-source priority select for one EX operand; the
// nearer producer (current EX) wins over the farther one (current MEM).
module fwd_src_sel
    import fwd_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  stage_tag_t        ex_tag,
    input  stage_tag_t        mem_tag,
    output fwd_sel_e          sel,
    output logic              load_hit
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit   = tag_hit(ex_tag, src, use_src);
        mem_hit  = tag_hit(mem_tag, src, use_src);
        sel      = SEL_IDEX;
        load_hit = 1'b0;
        // A load still in EX has no data yet; it must block the older MEM match.
        if (ex_hit) begin
            if (ex_tag.is_load) begin
                load_hit = 1'b1;
            end else begin
                sel = SEL_MEM;
            end
        end else if (mem_hit) begin
            sel = mem_tag.is_load ? SEL_LOAD : SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Optional performance counters are compiled in with FWD_PERF_CNT_EN.
module fwd_hazard_ctrl #(
    parameter int REG_AW = fwd_pkg::REG_AW
`ifdef FWD_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              dcache_stall,
    output logic [1:0]        rs_sel,
    output logic [1:0]        rt_sel,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              freeze
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_lu_stalls,
    output logic [CNT_W-1:0]  perf_fwds
`endif
);

    import fwd_pkg::*;

    // WB producers need no entry here: by the time the ID instruction reads its
    // operands in EX they have already retired into the register file.
    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t ex_d;
    fwd_sel_e   rs_sel_q;
    fwd_sel_e   rt_sel_q;
    fwd_sel_e   rs_sel_d;
    fwd_sel_e   rt_sel_d;
    logic       rs_load_hit;
    logic       rt_load_hit;
    logic       use_rt;
    logic       load_use;
    logic       issue;

    assign use_rt = id_use_rs2 & ~id_use_imm;

    fwd_src_sel u_rs_sel (
        .src      (id_rs1),
        .use_src  (id_use_rs1),
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .sel      (rs_sel_d),
        .load_hit (rs_load_hit)
    );

    fwd_src_sel u_rt_sel (
        .src      (id_rs2),
        .use_src  (use_rt),
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .sel      (rt_sel_d),
        .load_hit (rt_load_hit)
    );

    // Priority: freeze over flush over load-use.
    always_comb begin
        freeze      = dcache_stall;
        load_use    = ~dcache_stall & ~flush & id_valid & (rs_load_hit | rt_load_hit);
        stall_if_id = load_use;
        bubble_ex   = ~dcache_stall & (flush | load_use);
        issue       = id_valid & ~bubble_ex;
        ex_d        = '0;
        if (issue) begin
            ex_d = '{valid: 1'b1, rd: id_rd, wen: id_wen, is_load: id_is_load};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            rs_sel_q <= SEL_IDEX;
            rt_sel_q <= SEL_IDEX;
        end else if (!dcache_stall) begin
            mem_q    <= ex_q;
            ex_q     <= ex_d;
            rs_sel_q <= issue ? rs_sel_d : SEL_IDEX;
            rt_sel_q <= issue ? rt_sel_d : SEL_IDEX;
        end
    end

    assign rs_sel = rs_sel_q;
    assign rt_sel = rt_sel_q;

`ifdef FWD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (stall_if_id && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            end
            if (!dcache_stall && ((rs_sel_q != SEL_IDEX) || (rt_sel_q != SEL_IDEX))
                && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_lu_stalls = lu_cnt_q;
    assign perf_fwds      = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: expected selects are queued as each
// ID instruction is driven and popped after the edge that moves it into EX.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_use_imm;
    logic       id_wen, id_is_load, flush, dcache_stall;
    logic [1:0] rs_sel, rt_sel;
    logic       stall_if_id, bubble_ex, freeze;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_fwds;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       imm;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       fl;
        logic       ds;
        logic       st;
        logic       bub;
        logic [1:0] ers;
        logic [1:0] ert;
    } step_t;

    fwd_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_use_imm   (id_use_imm),
        .id_rd        (id_rd),
        .id_wen       (id_wen),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .dcache_stall (dcache_stall),
        .rs_sel       (rs_sel),
        .rt_sel       (rt_sel),
        .stall_if_id  (stall_if_id),
        .bubble_ex    (bubble_ex),
        .freeze       (freeze)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_lu_stalls (perf_lu_stalls),
        .perf_fwds      (perf_fwds)
`endif
    );

    always #5 clk = ~clk;

    function automatic step_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                 logic imm, logic [4:0] rd, logic wen, logic ld, logic fl,
                                 logic ds, logic st, logic bub, logic [1:0] ers, logic [1:0] ert);
        step_t s;
        s = '{v, rs1, u1, rs2, u2, imm, rd, wen, ld, fl, ds, st, bub, ers, ert};
        return s;
    endfunction

    function automatic step_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one ID cycle and records the selects it must produce in EX.
    task automatic apply(input step_t s);
        id_valid     = s.v;
        id_rs1       = s.rs1;
        id_use_rs1   = s.u1;
        id_rs2       = s.rs2;
        id_use_rs2   = s.u2;
        id_use_imm   = s.imm;
        id_rd        = s.rd;
        id_wen       = s.wen;
        id_is_load   = s.ld;
        flush        = s.fl;
        dcache_stall = s.ds;
        exp_q.push_back({s.ers, s.ert});
    endtask

    task automatic test_reset();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_use_imm = 0; id_rd = 0; id_wen = 0; id_is_load = 0; flush = 0; dcache_stall = 0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({rs_sel, rt_sel, stall_if_id, bubble_ex, freeze} !== 7'b0) begin
            errors++;
            $display("FAIL reset outputs got=%b exp=0000000", {rs_sel, rt_sel, stall_if_id, bubble_ex, freeze});
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (perf_lu_stalls !== 32'd0 || perf_fwds !== 32'd0) begin
            errors++;
            $display("FAIL reset counters got=%0d/%0d exp=0/0", perf_lu_stalls, perf_fwds);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ex_fwd();
        step_t rows[$];
        logic [3:0] exp;
        rows.push_back(mk(1, 1, 1, 2, 1, 0, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 6, 1, 5, 1, 0, 8, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01));
        rows.push_back(mk(1, 5, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01));
        rows.push_back(nop());
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if (stall_if_id !== rows[i].st || bubble_ex !== rows[i].bub) begin
                errors++;
                $display("FAIL ex_fwd[%0d] stall/bubble got=%b%b exp=%b%b", i, stall_if_id, bubble_ex, rows[i].st, rows[i].bub);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({rs_sel, rt_sel} !== exp) begin
                errors++;
                $display("FAIL ex_fwd[%0d] sels got=%b exp=%b", i, {rs_sel, rt_sel}, exp);
            end
        end
    endtask

    task automatic test_load_use();
        step_t rows[$];
        logic [3:0] exp;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 7, 1, 2, 1, 0, 9, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00));
        rows.push_back(mk(1, 7, 1, 2, 1, 0, 9, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00));
        rows.push_back(nop());
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if (stall_if_id !== rows[i].st || bubble_ex !== rows[i].bub) begin
                errors++;
                $display("FAIL load_use[%0d] stall/bubble got=%b%b exp=%b%b", i, stall_if_id, bubble_ex, rows[i].st, rows[i].bub);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({rs_sel, rt_sel} !== exp) begin
                errors++;
                $display("FAIL load_use[%0d] sels got=%b exp=%b", i, {rs_sel, rt_sel}, exp);
            end
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (perf_lu_stalls !== 32'd1 || perf_fwds !== 32'd3) begin
            errors++;
            $display("FAIL perf_after_load_use got=%0d/%0d exp=1/3", perf_lu_stalls, perf_fwds);
        end
`endif
    endtask

    task automatic test_priority_x0_imm();
        step_t rows[$];
        logic [3:0] exp;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        rows.push_back(nop());
        rows.push_back(nop());
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10));
        rows.push_back(nop());
        rows.push_back(nop());
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 0, 1, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 9, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        rows.push_back(mk(1, 9, 1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00));
        rows.push_back(mk(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(nop());
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if (stall_if_id !== rows[i].st || bubble_ex !== rows[i].bub) begin
                errors++;
                $display("FAIL prio_x0_imm[%0d] stall/bubble got=%b%b exp=%b%b", i, stall_if_id, bubble_ex, rows[i].st, rows[i].bub);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({rs_sel, rt_sel} !== exp) begin
                errors++;
                $display("FAIL prio_x0_imm[%0d] sels got=%b exp=%b", i, {rs_sel, rt_sel}, exp);
            end
        end
    endtask

    task automatic test_freeze();
        step_t rows[$];
        logic [3:0] exp;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 4, 1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00));
        for (int k = 0; k < 4; k++)
            rows.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        rows.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
        rows.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00));
        rows.push_back(nop());
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if (stall_if_id !== rows[i].st || bubble_ex !== rows[i].bub || freeze !== rows[i].ds) begin
                errors++;
                $display("FAIL freeze[%0d] stall/bubble/freeze got=%b%b%b exp=%b%b%b", i,
                         stall_if_id, bubble_ex, freeze, rows[i].st, rows[i].bub, rows[i].ds);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({rs_sel, rt_sel} !== exp) begin
                errors++;
                $display("FAIL freeze[%0d] sels got=%b exp=%b", i, {rs_sel, rt_sel}, exp);
            end
        end
    endtask

    task automatic test_flush();
        step_t rows[$];
        logic [3:0] exp;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        rows.push_back(mk(1, 7, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00));
        rows.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b11, 2'b00));
        rows.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        rows.push_back(nop());
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if (stall_if_id !== rows[i].st || bubble_ex !== rows[i].bub) begin
                errors++;
                $display("FAIL flush[%0d] stall/bubble got=%b%b exp=%b%b", i, stall_if_id, bubble_ex, rows[i].st, rows[i].bub);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({rs_sel, rt_sel} !== exp) begin
                errors++;
                $display("FAIL flush[%0d] sels got=%b exp=%b", i, {rs_sel, rt_sel}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t rows[$];
        logic [3:0] exp;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        rows.push_back(mk(1, 2, 1, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10));
        rows.push_back(mk(1, 3, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10));
        rows.push_back(nop());
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if (stall_if_id !== rows[i].st || bubble_ex !== rows[i].bub) begin
                errors++;
                $display("FAIL back_to_back[%0d] stall/bubble got=%b%b exp=%b%b", i, stall_if_id, bubble_ex, rows[i].st, rows[i].bub);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if ({rs_sel, rt_sel} !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d] sels got=%b exp=%b", i, {rs_sel, rt_sel}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        apply(mk(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tick();
        apply(mk(1, 4, 1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00));
        tick();
        exp_q.delete();
        apply(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
        exp_q.delete();
        #1;
        checks++;
        if (stall_if_id !== 1'b1 || rs_sel !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_pre stall/rs_sel got=%b/%b exp=1/01", stall_if_id, rs_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0 || {rs_sel, rt_sel} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_clear stall/bubble/sels got=%b%b/%b exp=00/0000", stall_if_id, bubble_ex, {rs_sel, rt_sel});
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_post stall/bubble got=%b%b exp=00", stall_if_id, bubble_ex);
        end
        tick();
        checks++;
        if ({rs_sel, rt_sel} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_first_issue sels got=%b exp=0000", {rs_sel, rt_sel});
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (perf_lu_stalls !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_counter got=%0d exp=0", perf_lu_stalls);
        end
`endif
        apply(nop());
        tick();
        apply(nop());
        tick();
        exp_q.delete();
    endtask

`ifdef FWD_PERF_CNT_EN
    task automatic test_perf_saturate();
        force dut.lu_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.lu_cnt_q;
        for (int k = 0; k < 2; k++) begin
            apply(mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
            tick();
            apply(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
            tick();
            apply(nop());
            tick();
        end
        exp_q.delete();
        checks++;
        if (perf_lu_stalls !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_saturate got=%h exp=ffffffff", perf_lu_stalls);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_priority_x0_imm();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef FWD_PERF_CNT_EN
        test_perf_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
